// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order reorder buffer: tag allocation, CDB capture, in-order commit
module reorder_buffer #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       alloc_valid,
    input  logic [4:0]                 alloc_dest,
    output logic                       alloc_ready,
    output logic [4:0]                 alloc_tag,
    input  logic                       cdb_valid,
    input  logic [4:0]                 cdb_tag,
    input  logic [31:0]                cdb_value,
    input  logic [4:0]                 query_tag_j,
    output logic                       query_ready_j,
    output logic [31:0]                query_value_j,
    input  logic [4:0]                 query_tag_k,
    output logic                       query_ready_k,
    output logic [31:0]                query_value_k,
    output logic                       load_reg,
    output logic [4:0]                 reg_id_rob,
    output logic [31:0]                reg_val,
    output logic [4:0]                 tag_rob,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [4:0]    MAX_TAG  = 5'(DEPTH);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] done;
    logic [4:0]       dest  [DEPTH];
    logic [31:0]      value [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    cnt;

    logic          commit;
    logic          do_alloc;
    logic          cdb_hit;
    logic [PW-1:0] cdb_idx;
    logic [PW-1:0] qj_idx;
    logic [PW-1:0] qk_idx;

    function automatic logic tag_ok(input logic [4:0] t);
        return (t != 5'd0) && (t <= MAX_TAG);
    endfunction

    // Tag t lives in entry t-1; only meaningful when tag_ok(t).
    function automatic logic [PW-1:0] tag_idx(input logic [4:0] t);
        logic [4:0] d;
        d = t - 5'd1;
        return d[PW-1:0];
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign cdb_idx = tag_idx(cdb_tag);
    assign qj_idx  = tag_idx(query_tag_j);
    assign qk_idx  = tag_idx(query_tag_k);

    assign commit   = busy[head] & done[head];
    assign do_alloc = alloc_valid & alloc_ready;
    assign cdb_hit  = cdb_valid & tag_ok(cdb_tag) & busy[cdb_idx];

    assign alloc_ready = (cnt != FULL_CNT);
    assign alloc_tag   = 5'(tail) + 5'd1;
    assign count       = cnt;
    assign empty       = (cnt == '0);

    assign load_reg   = commit;
    assign reg_id_rob = commit ? dest[head]          : 5'd0;
    assign reg_val    = commit ? value[head]         : 32'd0;
    assign tag_rob    = commit ? 5'(head) + 5'd1     : 5'd0;

    assign query_ready_j = tag_ok(query_tag_j) & busy[qj_idx] & done[qj_idx];
    assign query_value_j = query_ready_j ? value[qj_idx] : 32'd0;
    assign query_ready_k = tag_ok(query_tag_k) & busy[qk_idx] & done[qk_idx];
    assign query_value_k = query_ready_k ? value[qk_idx] : 32'd0;

    // Commit clears after the CDB update so a late broadcast to the retiring head is dropped.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy <= '0;
            done <= '0;
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (cdb_hit) begin
                done[cdb_idx] <= 1'b1;
            end
            if (commit) begin
                busy[head] <= 1'b0;
                done[head] <= 1'b0;
                head       <= next_ptr(head);
            end
            if (do_alloc) begin
                busy[tail] <= 1'b1;
                done[tail] <= 1'b0;
                tail       <= next_ptr(tail);
            end
            if (do_alloc && !commit) begin
                cnt <= cnt + 1'b1;
            end else if (!do_alloc && commit) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cdb_hit) begin
            value[cdb_idx] <= cdb_value;
        end
        if (do_alloc) begin
            dest[tail] <= alloc_dest;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - randomized and directed bench for reorder_buffer against a queue model
module tb_reorder_buffer;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          alloc_valid;
    logic [4:0]    alloc_dest;
    logic          alloc_ready;
    logic [4:0]    alloc_tag;
    logic          cdb_valid;
    logic [4:0]    cdb_tag;
    logic [31:0]   cdb_value;
    logic [4:0]    query_tag_j;
    logic          query_ready_j;
    logic [31:0]   query_value_j;
    logic [4:0]    query_tag_k;
    logic          query_ready_k;
    logic [31:0]   query_value_k;
    logic          load_reg;
    logic [4:0]    reg_id_rob;
    logic [31:0]   reg_val;
    logic [4:0]    tag_rob;
    logic [CW-1:0] count;
    logic          empty;

    reorder_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .query_tag_j(query_tag_j), .query_ready_j(query_ready_j), .query_value_j(query_value_j),
        .query_tag_k(query_tag_k), .query_ready_k(query_ready_k), .query_value_k(query_value_k),
        .load_reg(load_reg), .reg_id_rob(reg_id_rob), .reg_val(reg_val), .tag_rob(tag_rob),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: program-order queue of tags plus per-tag status.
    int          rob_q[$];
    bit          m_busy [32];
    bit          m_done [32];
    logic [4:0]  m_dest [32];
    logic [31:0] m_val  [32];
    int          next_tag;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        rob_q.delete();
        for (int i = 0; i < 32; i++) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b0;
        end
        next_tag = 1;
    endtask

    function automatic bit q_ready(input logic [4:0] t);
        return (t >= 1) && (t <= DEPTH) && m_busy[t] && m_done[t];
    endfunction

    task automatic check_outputs();
        int  head_tag;
        bit  exp_commit;
        head_tag   = (rob_q.size() > 0) ? rob_q[0] : 0;
        exp_commit = (rob_q.size() > 0) && m_done[head_tag];
        check("count",       32'(count),       32'(rob_q.size()));
        check("empty",       32'(empty),       32'(rob_q.size() == 0));
        check("alloc_ready", 32'(alloc_ready), 32'(rob_q.size() != DEPTH));
        check("alloc_tag",   32'(alloc_tag),   32'(next_tag));
        check("load_reg",    32'(load_reg),    32'(exp_commit));
        check("reg_id_rob",  32'(reg_id_rob),  exp_commit ? 32'(m_dest[head_tag]) : 32'd0);
        check("reg_val",     reg_val,          exp_commit ? m_val[head_tag] : 32'd0);
        check("tag_rob",     32'(tag_rob),     exp_commit ? 32'(head_tag) : 32'd0);
        check("qready_j",    32'(query_ready_j), 32'(q_ready(query_tag_j)));
        check("qvalue_j",    query_value_j,      q_ready(query_tag_j) ? m_val[query_tag_j] : 32'd0);
        check("qready_k",    32'(query_ready_k), 32'(q_ready(query_tag_k)));
        check("qvalue_k",    query_value_k,      q_ready(query_tag_k) ? m_val[query_tag_k] : 32'd0);
    endtask

    task automatic model_update();
        bit commit_now;
        bit had_room;
        int t;
        if (flush) begin
            model_reset();
            return;
        end
        commit_now = (rob_q.size() > 0) && m_done[rob_q[0]];
        had_room   = (rob_q.size() != DEPTH);
        if (cdb_valid && cdb_tag >= 1 && cdb_tag <= DEPTH && m_busy[cdb_tag]) begin
            m_done[cdb_tag] = 1'b1;
            m_val[cdb_tag]  = cdb_value;
        end
        if (commit_now) begin
            t = rob_q.pop_front();
            m_busy[t] = 1'b0;
            m_done[t] = 1'b0;
        end
        if (alloc_valid && had_room) begin
            rob_q.push_back(next_tag);
            m_busy[next_tag] = 1'b1;
            m_done[next_tag] = 1'b0;
            m_dest[next_tag] = alloc_dest;
            next_tag = (next_tag == DEPTH) ? 1 : next_tag + 1;
        end
    endtask

    // One cycle: drive, check pre-edge outputs, advance model, clock, return inputs to idle.
    task automatic step(input logic fl, input logic av, input logic [4:0] ad,
                        input logic cv, input logic [4:0] ct, input logic [31:0] cval);
        flush = fl; alloc_valid = av; alloc_dest = ad;
        cdb_valid = cv; cdb_tag = ct; cdb_value = cval;
        #1;
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
        flush = 1'b0; alloc_valid = 1'b0; cdb_valid = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic alloc(input logic [4:0] d);
        step(1'b0, 1'b1, d, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic cdb(input logic [4:0] t, input logic [31:0] v);
        step(1'b0, 1'b0, 5'd0, 1'b1, t, v);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_dest = 5'd0;
        cdb_valid = 1'b0; cdb_tag = 5'd0; cdb_value = 32'd0;
        query_tag_j = 5'd0; query_tag_k = 5'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        check("rst_alloc_tag",   32'(alloc_tag),   32'd1);
        check("rst_empty",       32'(empty),       32'd1);
        check("rst_count",       32'(count),       32'd0);
        check("rst_load_reg",    32'(load_reg),    32'd0);

        // In-order commit despite out-of-order completion
        alloc(5'd5);
        alloc(5'd6);
        cdb(5'd2, 32'hBB);
        check("ooo_no_commit", 32'(load_reg), 32'd0);
        cdb(5'd1, 32'hAA);
        check("c1_load", 32'(load_reg), 32'd1);
        check("c1_reg",  32'(reg_id_rob), 32'd5);
        check("c1_val",  reg_val, 32'hAA);
        check("c1_tag",  32'(tag_rob), 32'd1);
        idle();
        check("c2_reg",  32'(reg_id_rob), 32'd6);
        check("c2_val",  reg_val, 32'hBB);
        check("c2_tag",  32'(tag_rob), 32'd2);
        idle();
        check("c2_empty", 32'(empty), 32'd1);

        // Fill, overflow attempt, wrap of allocation tag
        step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < DEPTH; i++) alloc(5'(i + 1));
        check("full_ready", 32'(alloc_ready), 32'd0);
        alloc(5'd31);
        check("full_count", 32'(count), 32'(DEPTH));
        cdb(5'd1, 32'h11);
        idle();
        check("wrap_ready", 32'(alloc_ready), 32'd1);
        check("wrap_tag",   32'(alloc_tag),   32'd1);

        // Flush beats a same-cycle CDB write
        step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        alloc(5'd1); alloc(5'd2); alloc(5'd3);
        cdb(5'd1, 32'h77);
        step(1'b1, 1'b0, 5'd0, 1'b1, 5'd2, 32'h99);
        check("flush_count", 32'(count), 32'd0);
        check("flush_load",  32'(load_reg), 32'd0);
        check("flush_tag",   32'(alloc_tag), 32'd1);
        idle();
        check("flush_nocommit", 32'(load_reg), 32'd0);

        // Query after capture, no same-cycle visibility
        alloc(5'd1); alloc(5'd2); alloc(5'd3);
        query_tag_j = 5'd3; query_tag_k = 5'd0;
        #1;
        check("q_before", 32'(query_ready_j), 32'd0);
        cdb(5'd3, 32'h1234);
        check("q_ready_j", 32'(query_ready_j), 32'd1);
        check("q_value_j", query_value_j, 32'h1234);
        check("q_ready_k", 32'(query_ready_k), 32'd0);

        // Ignored CDBs, then simultaneous alloc and commit at count 4
        cdb(5'd7, 32'hDEAD);
        cdb(5'd0, 32'hBEEF);
        check("ign_count", 32'(count), 32'd3);
        alloc(5'd4);
        cdb(5'd1, 32'h55);
        check("ac_pre", 32'(count), 32'd4);
        alloc(5'd9);
        check("ac_count", 32'(count), 32'd4);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] ct;
            if (rob_q.size() > 0 && $urandom_range(0, 3) != 0)
                ct = 5'(rob_q[$urandom_range(0, rob_q.size() - 1)]);
            else
                ct = 5'($urandom_range(0, 31));
            query_tag_j = 5'($urandom_range(0, 10));
            query_tag_k = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, DEPTH));
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 2) != 0,
                 5'($urandom_range(0, 31)),
                 $urandom_range(0, 2) != 0,
                 ct,
                 $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
